reg_write_queue: RTL and testbench
==================================

# reg_write_queue

Buffered write-side front end for the 32 x 64-bit register file. It accepts register writebacks from late-completing producers, such as loads and multi-cycle ALU ops, and holds them in a small in-order queue. It drains them one per cycle into the register file's single write port (RegWrite / WriteRegister / WriteData) whenever the port is granted. It also provides two forwarding lookups so that readers see queued, not-yet-written values.

## Interface
- DEPTH, 4, number of queue entries; power of two, 2..16
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer has a writeback this cycle
- in_ready  output  1  queue can accept; equals (count < DEPTH)
- in_reg  input  5  destination register number
- in_data  input  64  destination value
- drain_en  input  1  write port granted to the queue this cycle
- RegWrite  output  1  write enable to register file
- WriteRegister  output  5  register number to write
- WriteData  output  64  value to write
- q_reg1, q_reg2  input  5  lookup register numbers (mirror ReadRegister1/2)
- fwd_hit1, fwd_hit2  output  1  a queued entry targets q_regN
- fwd_data1, fwd_data2  output  64  value of the youngest matching entry; 0 when no hit
- count  output  $clog2(DEPTH)+1  current occupancy

## Operation
- Circular buffer with head pointer, tail pointer and count. Entries hold {reg[4:0], data[63:0]} plus a valid bit.
- Accept: when in_valid & in_ready, a write with in_reg != 31 is stored at the tail. The tail then advances modulo DEPTH.
- A write to register 31 (the hardwired zero register) is accepted (the handshake completes) but discarded: nothing is stored and count is unchanged.
- Drain: RegWrite = drain_en & (count != 0). WriteRegister and WriteData come combinationally from the head entry.
  - When the queue is empty, WriteRegister = 31 and WriteData = 0.
  - On a clock edge with RegWrite = 1, the head is freed and advances modulo DEPTH.
- Simultaneous accept and drain: both take effect on the same edge and count is unchanged.
- in_ready depends only on registered count. It is not raised by a same-cycle drain, so when full the queue accepts nothing that cycle even if draining.
- Drain order equals accept order. No coalescing of writes to the same register; each is written in turn.
- Forwarding for each lookup port:
  - All valid entries are compared against q_regN; the youngest match (closest to the tail) wins.
  - An entry being drained this cycle still participates.
  - The in_data being accepted this cycle does not participate.
  - q_regN = 31 never hits.
- Overflow cannot occur: in_valid while in_ready = 0 is ignored, with no state change.
- Underflow cannot occur: drain_en while empty does nothing.

## Timing
- Reset (reset_n low, asynchronous): head = tail = 0, count = 0, all valid bits clear.
  - Outputs during and after reset: in_ready = 1, RegWrite = 0, WriteRegister = 31, WriteData = 0, fwd_hit = 0, fwd_data = 0, count = 0.
- Reset asserted mid-operation discards all queued writes immediately. No partial write is issued after reset assertion.
- Accept-to-visible latency:
  - An entry accepted at edge N is visible on fwd_* and at the head (if the queue was empty) in the cycle after edge N.
  - If drain_en is high in that cycle, it is written to the register file at edge N+1.
- Throughput: one accept and one drain per cycle.
- All outputs except count-derived in_ready are combinational from registered state plus drain_en/q_reg inputs. No input-to-output path exists from in_valid, in_reg or in_data.
- Pointer wrap: DEPTH-1 to 0 with no bubble.

## Test plan
- Reset/empty:
  - Stimulus: hold reset_n low, release, then drive drain_en = 1 for 5 cycles.
  - Required: RegWrite = 0 throughout, WriteRegister = 31, in_ready = 1, count = 0.
- Fill and drain order:
  - Stimulus: with drain_en = 0, accept writes to X1..X4 with data 0x11, 0x22, 0x33, 0x44.
  - Required: count = 4 and in_ready = 0; a fifth write is ignored.
  - Then: drain_en = 1 produces X1/0x11, X2/0x22, X3/0x33, X4/0x44 on consecutive cycles, then RegWrite = 0.
- Forwarding youngest wins:
  - Stimulus: queue X5 = 0xAAAA then X5 = 0xBBBB; drive q_reg1 = 5 and q_reg2 = 6.
  - Required: fwd_hit1 = 1 with fwd_data1 = 0xBBBB, and fwd_hit2 = 0 with fwd_data2 = 0.
  - Then: after one drain, fwd_data1 is still 0xBBBB.
- Zero register:
  - Stimulus: accept X31 = 0xDEAD.
  - Required: handshake completes, count is unchanged, no RegWrite for X31, and a q_reg1 = 31 lookup gives fwd_hit1 = 0.
- Simultaneous push/pop at wrap:
  - Stimulus: run 3*DEPTH cycles with in_valid = 1 and drain_en = 1, using data = cycle index.
  - Required: count holds at 1 after the first cycle, and the written sequence matches the accepted sequence with no loss across pointer wrap.
- Async reset mid-stream:
  - Stimulus: with 3 entries queued, pulse reset_n low between clock edges.
  - Required: RegWrite drops immediately, count = 0, and no stale entry is written after release.

Source files
------------

// File: rtl/reg_write_queue.sv
// reg_write_queue
//   In-order write buffer in front of the 32 x 64-bit register file's single
//   write port. Late producers push {reg, data} writebacks. The queue drains
//   one entry per cycle whenever the write port is granted. Two lookup ports
//   forward the youngest queued value for a register, so readers see writes
//   that are still pending.
//
// Ports
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     producer handshake; in_ready = (count < DEPTH)
//   in_reg, in_data       writeback destination and value (X31 is discarded)
//   drain_en              write port granted to the queue this cycle
//   RegWrite, WriteRegister, WriteData
//                         register-file write port, driven from the head entry
//   q_reg1/2              lookup register numbers
//   fwd_hit1/2, fwd_data1/2
//                         youngest queued match for each lookup (0 on miss)
//   count                 current occupancy
module reg_write_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_reg,
  input  logic [63:0]              in_data,
  input  logic                     drain_en,
  output logic                     RegWrite,
  output logic [4:0]               WriteRegister,
  output logic [63:0]              WriteData,
  input  logic [4:0]               q_reg1,
  input  logic [4:0]               q_reg2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [63:0]              fwd_data1,
  output logic [63:0]              fwd_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [4:0]       reg_q  [DEPTH];
  logic [63:0]      data_q [DEPTH];

  logic push;
  logic pop;

  always_comb begin
    in_ready = (count_q < FULL);
    pop      = drain_en & (count_q != '0);
    // A write to X31 completes the handshake but is never stored.
    push     = in_valid & in_ready & (in_reg != 5'd31);

    head_d  = pop  ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(push) - CW'(pop);

    // Full blocks push, empty blocks pop, so head and tail never collide here.
    valid_d = valid_q;
    if (pop)  valid_d[head_q] = 1'b0;
    if (push) valid_d[tail_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload storage needs no reset; the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      reg_q[tail_q]  <= in_reg;
      data_q[tail_q] <= in_data;
    end
  end

  always_comb begin
    RegWrite      = pop;
    WriteRegister = (count_q != '0) ? reg_q[head_q]  : 5'd31;
    WriteData     = (count_q != '0) ? data_q[head_q] : '0;
  end

  // Walk entries from oldest (head) to youngest, so later matches overwrite
  // earlier ones and the youngest wins. The head entry being drained still
  // counts because valid bits only clear at the edge.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (valid_q[idx] && (reg_q[idx] == q_reg1) && (q_reg1 != 5'd31)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = data_q[idx];
      end
      if (valid_q[idx] && (reg_q[idx] == q_reg2) && (q_reg2 != 5'd31)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = data_q[idx];
      end
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_reg_write_queue.sv
module tb_reg_write_queue;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_reg;
  logic [63:0]   in_data;
  logic          drain_en;
  logic          RegWrite;
  logic [4:0]    WriteRegister;
  logic [63:0]   WriteData;
  logic [4:0]    q_reg1, q_reg2;
  logic          fwd_hit1, fwd_hit2;
  logic [63:0]   fwd_data1, fwd_data2;
  logic [CW-1:0] count;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: pending writes oldest-first, plus logs of what was
  // accepted (non-X31) and what was written to the register file.
  logic [68:0] mq[$];
  logic [68:0] alog[$];
  logic [68:0] wlog[$];

  reg_write_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .drain_en(drain_en),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .q_reg1(q_reg1), .q_reg2(q_reg2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic void mfwd(input logic [4:0] q, output logic hit, output logic [63:0] d);
    hit = 1'b0;
    d   = '0;
    if (q != 5'd31) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i][68:64] == q) begin
          hit = 1'b1;
          d   = mq[i][63:0];
          break;
        end
      end
    end
  endfunction

  // Advance one clock edge and update the model from the inputs seen there.
  task automatic tick();
    logic acc, pop;
    logic [68:0] e;
    acc = reset_n && in_valid && (mq.size() < DEPTH);
    pop = reset_n && drain_en && (mq.size() > 0);
    e   = {in_reg, in_data};
    @(posedge clk);
    if (pop) wlog.push_back(mq.pop_front());
    if (acc && in_reg != 5'd31) begin
      mq.push_back(e);
      alog.push_back(e);
    end
    #1;
  endtask

  task automatic push_one(input logic [4:0] r, input logic [63:0] d);
    in_valid = 1'b1; in_reg = r; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_reg = '0; in_data = '0;
    drain_en = 1'b1; q_reg1 = 5'd0; q_reg2 = 5'd0;
    #12;
    n_chk++;
    if (RegWrite !== 1'b0 || WriteRegister !== 5'd31 || WriteData !== 64'd0 ||
        in_ready !== 1'b1 || count !== '0 || fwd_hit1 !== 1'b0 || fwd_data1 !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got rw=%0b wr=%0d wd=%0h rdy=%0b cnt=%0d hit=%0b fd=%0h expected 0 31 0 1 0 0 0",
               RegWrite, WriteRegister, WriteData, in_ready, count, fwd_hit1, fwd_data1);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++;
      if (RegWrite !== 1'b0 || WriteRegister !== 5'd31 || in_ready !== 1'b1 || count !== '0) begin
        n_fail++;
        $display("FAIL reset_empty_drain: got rw=%0b wr=%0d rdy=%0b cnt=%0d expected 0 31 1 0",
                 RegWrite, WriteRegister, in_ready, count);
      end
    end
    drain_en = 1'b0;
  endtask

  task automatic test_fill_drain();
    drain_en = 1'b0;
    for (int i = 1; i <= 4; i++) push_one(5'(i), 64'(i * 'h11));
    n_chk++;
    if (count !== CW'(4) || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: got cnt=%0d rdy=%0b expected 4 0", count, in_ready);
    end
    push_one(5'd7, 64'h55);
    n_chk++;
    if (count !== CW'(4)) begin
      n_fail++;
      $display("FAIL fill_overflow_ignored: got cnt=%0d expected 4", count);
    end
    drain_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      n_chk++;
      if (RegWrite !== 1'b1 || WriteRegister !== 5'(i) || WriteData !== 64'(i * 'h11)) begin
        n_fail++;
        $display("FAIL drain_order: got rw=%0b X%0d=%0h expected 1 X%0d=%0h",
                 RegWrite, WriteRegister, WriteData, i, i * 'h11);
      end
      tick();
    end
    #1;
    n_chk++;
    if (RegWrite !== 1'b0 || count !== '0 || WriteRegister !== 5'd31) begin
      n_fail++;
      $display("FAIL drain_empty: got rw=%0b cnt=%0d wr=%0d expected 0 0 31", RegWrite, count, WriteRegister);
    end
    drain_en = 1'b0;
  endtask

  task automatic test_forward();
    drain_en = 1'b0;
    push_one(5'd5, 64'hAAAA);
    push_one(5'd5, 64'hBBBB);
    q_reg1 = 5'd5; q_reg2 = 5'd6;
    // X6 is being accepted this cycle; it must not be visible yet.
    in_valid = 1'b1; in_reg = 5'd6; in_data = 64'hCC;
    #1;
    n_chk++;
    if (fwd_hit1 !== 1'b1 || fwd_data1 !== 64'hBBBB) begin
      n_fail++;
      $display("FAIL fwd_youngest: got hit=%0b data=%0h expected 1 bbbb", fwd_hit1, fwd_data1);
    end
    n_chk++;
    if (fwd_hit2 !== 1'b0 || fwd_data2 !== 64'd0) begin
      n_fail++;
      $display("FAIL fwd_miss_incoming: got hit=%0b data=%0h expected 0 0", fwd_hit2, fwd_data2);
    end
    tick();
    in_valid = 1'b0;
    drain_en = 1'b1;
    tick();
    n_chk++;
    if (fwd_hit1 !== 1'b1 || fwd_data1 !== 64'hBBBB || fwd_hit2 !== 1'b1 || fwd_data2 !== 64'hCC) begin
      n_fail++;
      $display("FAIL fwd_after_drain: got h1=%0b d1=%0h h2=%0b d2=%0h expected 1 bbbb 1 cc",
               fwd_hit1, fwd_data1, fwd_hit2, fwd_data2);
    end
    // Head is X5=BBBB and is draining this cycle: it must still forward.
    n_chk++;
    if (RegWrite !== 1'b1 || fwd_hit1 !== 1'b1 || fwd_data1 !== 64'hBBBB) begin
      n_fail++;
      $display("FAIL fwd_draining_entry: got rw=%0b hit=%0b data=%0h expected 1 1 bbbb",
               RegWrite, fwd_hit1, fwd_data1);
    end
    tick();
    tick();
    n_chk++;
    if (fwd_hit1 !== 1'b0 || fwd_data1 !== 64'd0 || fwd_hit2 !== 1'b0 || count !== '0) begin
      n_fail++;
      $display("FAIL fwd_cleared: got h1=%0b d1=%0h h2=%0b cnt=%0d expected 0 0 0 0",
               fwd_hit1, fwd_data1, fwd_hit2, count);
    end
    drain_en = 1'b0;
  endtask

  task automatic test_zero_reg();
    drain_en = 1'b0;
    push_one(5'd9, 64'h1);
    wlog.delete();
    in_valid = 1'b1; in_reg = 5'd31; in_data = 64'hDEAD;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_handshake: got rdy=%0b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    q_reg1 = 5'd31;
    #1;
    n_chk++;
    if (count !== CW'(1) || fwd_hit1 !== 1'b0 || fwd_data1 !== 64'd0) begin
      n_fail++;
      $display("FAIL zero_discard: got cnt=%0d hit=%0b data=%0h expected 1 0 0", count, fwd_hit1, fwd_data1);
    end
    drain_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if (RegWrite === 1'b1 && WriteRegister === 5'd31) begin
        n_fail++;
        $display("FAIL zero_no_write: got RegWrite to X31 expected none");
      end
      tick();
    end
    n_chk++;
    if (wlog.size() != 1 || wlog[0] !== {5'd9, 64'h1}) begin
      n_fail++;
      $display("FAIL zero_written: got %0d writes expected 1 write of X9=1", wlog.size());
    end
    drain_en = 1'b0;
  endtask

  task automatic test_back_to_back_wrap();
    alog.delete();
    wlog.delete();
    in_valid = 1'b1; drain_en = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      in_reg  = 5'($urandom_range(1, 30));
      in_data = 64'(i);
      #1;
      n_chk++;
      if (RegWrite !== (i > 0) || (i > 0 && WriteData !== 64'(i - 1))) begin
        n_fail++;
        $display("FAIL wrap_stream: got rw=%0b wd=%0h expected %0b %0h", RegWrite, WriteData, i > 0, i - 1);
      end
      tick();
      n_chk++;
      if (count !== CW'(1)) begin
        n_fail++;
        $display("FAIL wrap_count: got %0d expected 1", count);
      end
    end
    in_valid = 1'b0;
    tick();
    n_chk++;
    if (wlog.size() != 3 * DEPTH || alog.size() != 3 * DEPTH || count !== '0) begin
      n_fail++;
      $display("FAIL wrap_len: got writes=%0d accepts=%0d cnt=%0d expected %0d %0d 0",
               wlog.size(), alog.size(), count, 3 * DEPTH, 3 * DEPTH);
    end else begin
      for (int i = 0; i < 3 * DEPTH; i++) begin
        n_chk++;
        if (wlog[i] !== alog[i]) begin
          n_fail++;
          $display("FAIL wrap_seq[%0d]: got %0h expected %0h", i, wlog[i], alog[i]);
        end
      end
    end
    drain_en = 1'b0;
  endtask

  task automatic test_random();
    logic eh1, eh2;
    logic [63:0] ed1, ed2;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      drain_en = ($urandom_range(0, 2) != 0);
      in_reg   = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      in_data  = {$urandom, $urandom};
      q_reg1   = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      q_reg2   = 5'($urandom_range(0, 31));
      #1;
      mfwd(q_reg1, eh1, ed1);
      mfwd(q_reg2, eh2, ed2);
      n_chk++;
      if (count !== CW'(mq.size()) || in_ready !== (mq.size() < DEPTH) ||
          RegWrite !== (drain_en && mq.size() > 0)) begin
        n_fail++;
        $display("FAIL rand_ctrl[%0d]: got cnt=%0d rdy=%0b rw=%0b expected %0d %0b %0b", c,
                 count, in_ready, RegWrite, mq.size(), mq.size() < DEPTH, drain_en && mq.size() > 0);
      end
      n_chk++;
      if (mq.size() > 0 ? (WriteRegister !== mq[0][68:64] || WriteData !== mq[0][63:0])
                        : (WriteRegister !== 5'd31 || WriteData !== 64'd0)) begin
        n_fail++;
        $display("FAIL rand_head[%0d]: got X%0d=%0h", c, WriteRegister, WriteData);
      end
      n_chk++;
      if (fwd_hit1 !== eh1 || fwd_data1 !== ed1 || fwd_hit2 !== eh2 || fwd_data2 !== ed2) begin
        n_fail++;
        $display("FAIL rand_fwd[%0d]: got %0b/%0h %0b/%0h expected %0b/%0h %0b/%0h", c,
                 fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, eh1, ed1, eh2, ed2);
      end
      tick();
    end
    in_valid = 1'b0;
    drain_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick();
    drain_en = 1'b0;
  endtask

  task automatic test_async_reset();
    drain_en = 1'b0;
    push_one(5'd1, 64'h101);
    push_one(5'd2, 64'h202);
    push_one(5'd3, 64'h303);
    drain_en = 1'b1;
    q_reg1 = 5'd2;
    #1;
    n_chk++;
    if (RegWrite !== 1'b1 || count !== CW'(3)) begin
      n_fail++;
      $display("FAIL areset_pre: got rw=%0b cnt=%0d expected 1 3", RegWrite, count);
    end
    #1 reset_n = 1'b0;
    mq.delete();
    #1;
    n_chk++;
    if (RegWrite !== 1'b0 || count !== '0 || WriteRegister !== 5'd31 || fwd_hit1 !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_immediate: got rw=%0b cnt=%0d wr=%0d hit=%0b rdy=%0b expected 0 0 31 0 1",
               RegWrite, count, WriteRegister, fwd_hit1, in_ready);
    end
    tick();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if (RegWrite !== 1'b0 || count !== '0) begin
        n_fail++;
        $display("FAIL areset_no_stale: got rw=%0b cnt=%0d X%0d expected 0 0", RegWrite, count, WriteRegister);
      end
    end
    drain_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_forward();
    test_zero_reg();
    test_back_to_back_wrap();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
